// File: rtl/imem_fetch_controller.sv
// imem_fetch_controller
//   Fetch-stage sequencer and sole owner of the instruction memory port.
//   The block has four states. LOAD writes loader words into the memory.
//   RUN fetches one instruction per cycle into the IF/ID register.
//   HALT is entered once the PC runs past the end of memory. IDLE waits
//   for a load or start request.
//   In RUN, a redirect takes priority over a stall, and a stall takes
//   priority over a normal advance.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   start                      IDLE/HALT -> RUN at RESET_PC
//   load_en                    IDLE -> LOAD request (wins over start)
//   load_valid/idx/data/done   loader beat interface; load_ready high in LOAD
//   stall                      hold PC and IF/ID (RUN only)
//   redirect, redirect_pc      branch/jump target, flushes IF/ID (RUN only)
//   imem_addr, imem_instr      combinational read port (addr = pc)
//   imem_wr_en/addr/data       write port, active only in LOAD
//   pc                         current fetch PC
//   ifid_instr/pc4/valid       IF/ID pipeline register
//   state                      IDLE=0, LOAD=1, RUN=2, HALT=3
module imem_fetch_controller #(
    parameter int unsigned DEPTH    = 32,
    parameter logic [31:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     load_en,
    input  logic                     load_valid,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [31:0]              load_data,
    input  logic                     load_done,
    output logic                     load_ready,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_instr,
    output logic                     imem_wr_en,
    output logic [31:0]              imem_wr_addr,
    output logic [31:0]              imem_wr_data,
    output logic [31:0]              pc,
    output logic [31:0]              ifid_instr,
    output logic [31:0]              ifid_pc4,
    output logic                     ifid_valid,
    output logic [1:0]               state
);

    localparam int unsigned IW       = $clog2(DEPTH);
    localparam logic [31:0] PC_LIMIT = 32'(DEPTH * 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4;

    // 32-bit add; wraps modulo 2^32
    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (load_en) begin
                    state_d = LOAD;
                end else if (start) begin
                    state_d = RUN;
                    pc_d    = RESET_PC;
                    valid_d = 1'b0;
                end
            end
            LOAD: begin
                // the final beat is written in the same cycle it returns to IDLE
                if (load_valid && load_done) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (redirect) begin
                    pc_d    = {redirect_pc[31:2], 2'b00};
                    valid_d = 1'b0;
                    instr_d = '0;
                end else if (stall) begin
                    // hold everything
                end else if (pc_q < PC_LIMIT) begin
                    instr_d = imem_instr;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                end else begin
                    state_d = HALT;
                    valid_d = 1'b0;
                end
            end
            HALT: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    pc_d    = RESET_PC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_ready   = (state_q == LOAD);
    assign imem_wr_en   = (state_q == LOAD) && load_valid;
    assign imem_wr_addr = {{(32 - IW - 2){1'b0}}, load_idx, 2'b00};
    assign imem_wr_data = load_data;
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign ifid_instr   = instr_q;
    assign ifid_pc4     = pc4_q;
    assign ifid_valid   = valid_q;
    assign state        = state_q;

endmodule
